data_memory_sized: RTL and testbench
====================================

# data_memory_sized

Byte-addressed, parametrised data memory for the processor's MEM stage with sub-word loads and stores (byte/half/word/double), sign or zero extension, a registered one-cycle read response, misalignment/range error reporting and saturating access counters. It replaces the flat word-addressed data memory: the datapath presents one request per cycle (address = base + offset) and receives a response flag with load data on the following cycle.

## Interface
Parameters:
- DEPTH, 32, number of 64-bit words; power of two, ≥2
- ADDR_W, 8, byte-address width; must satisfy 2^ADDR_W ≥ DEPTH*8
- CNT_W, 16, width of each access counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  1  request valid this cycle
- we  input  1  1 = store, 0 = load (qualified by req)
- addr  input  ADDR_W  byte address
- size  input  2  00 byte, 01 half, 10 word, 11 double
- uns  input  1  load zero-extend when 1, sign-extend when 0; ignored for double and stores
- din  input  64  store data, right-aligned (low bytes used)
- rsp_valid  output  1  response for the request of the previous cycle
- rdata  output  64  extended load data; 0 for stores and errors
- err  output  1  previous request was misaligned or out of range
- ld_cnt  output  CNT_W  completed good loads, saturating
- st_cnt  output  CNT_W  completed good stores, saturating

## Operation
- Storage: DEPTH × 64-bit array, word index = addr[ADDR_W-1:3], lane = addr[2:0]. Contents are not reset.
- Error check on req: misaligned when size=01 and addr[0]≠0, size=10 and addr[1:0]≠0, size=11 and addr[2:0]≠0; out of range when addr ≥ DEPTH*8. On error: no write, rdata=0, err=1, counters unchanged.
- Store: writes only the size's byte lanes (1/2/4/8 bytes starting at lane) from din[7:0], [15:0], [31:0], [63:0]; other bytes of the word are preserved. rsp_valid=1, rdata=0, err=0, st_cnt+1.
- Load: reads the word and shifts the selected lanes down by lane*8. Extension from bit 7/15/31 unless uns=1. rsp_valid=1, err=0, ld_cnt+1.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- req=0: rsp_valid=0 next cycle; rdata and err return to 0.

## Timing
- Reset (async assert, sync release): rsp_valid=0, rdata=0, err=0, ld_cnt=0, st_cnt=0 immediately on rst_n low.
- Latency 1: request sampled at edge N, response valid after edge N; no stalls, one request accepted every cycle.
- Store write commits at the same edge that samples it. A load to the same address at edge N+1 returns the new data (store-then-load forwarding is via the array, no bypass needed).
- Only one request per cycle, so no simultaneous read/write conflicts.
- Reset asserted mid-operation: pending response discarded, a store sampled at an edge with rst_n low is not written. First request sampled at the first edge with rst_n high.

## Configuration
- DMEM_INIT_EN defined: at time zero, words 0..5 are preloaded with 0, 10, 20, 30, 40, −10 (64-bit two's complement); remaining words are 0. This preload is for simulation and benches.
- DMEM_INIT_EN undefined: no initialisation; contents are X until written.

## Test plan
- With DMEM_INIT_EN: load double at addr 16 → next cycle rsp_valid=1, rdata=20, err=0, ld_cnt=1.
- With DMEM_INIT_EN: load byte at addr 40, uns=0 → rdata=0xFFFF_FFFF_FFFF_FFF6. The same load with uns=1 → rdata=0x0000_0000_0000_00F6.
- Store half din=0xABCD at addr 10, then load double at addr 8 → rdata=0x0000_0000_ABCD_0000 when word 1 was 0 beforehand (other bytes preserved). The back-to-back load returns the new value.
- Misaligned store word at addr 6 → err=1, rdata=0, word 0 unchanged, st_cnt unchanged. Load at addr DEPTH*8 → err=1.
- Assert rst_n low while a store is sampled → no write, all outputs 0 immediately. After release, req=0 → rsp_valid stays 0.
- CNT_W=2: issue 5 good loads → ld_cnt reaches 3 and holds.

Source files
------------

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressed 64-bit-word data memory for the MEM stage.
// Accepts one request per cycle and answers the following cycle.
// Requests cover byte/half/word/double loads and stores. Loads are
// sign- or zero-extended. Misaligned and out-of-range requests are
// flagged with err. Good loads and good stores are tallied in
// saturating counters.
// Optional build macro DMEM_INIT_EN: preloads words 0..5 with
// 0, 10, 20, 30, 40, -10 and all remaining words with 0 (simulation only).
module data_memory_sized #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [63:0]       din_i,
  output logic              rsp_valid_o,
  output logic [63:0]       rdata_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  ld_cnt_o,
  output logic [CNT_W-1:0]  st_cnt_o
);

  localparam int unsigned    IDX_W = $clog2(DEPTH);
  // The first byte address past the end of the array.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 8);

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  // Byte-lane enables for an access of the given size, starting at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_BYTE:   m = 8'h01;
      SZ_HALF:   m = 8'h03;
      SZ_WORD:   m = 8'h0F;
      SZ_DOUBLE: m = 8'hFF;
      default:   m = 8'h00;
    endcase
    return m;
  endfunction

  // An access is misaligned when the lane bits below its natural size are non-zero.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lane);
    logic bad;
    case (size)
      SZ_BYTE:   bad = 1'b0;
      SZ_HALF:   bad = lane[0];
      SZ_WORD:   bad = (lane[1:0] != 2'b00);
      SZ_DOUBLE: bad = (lane != 3'b000);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Keep only the low bytes of store data that the size actually writes.
  function automatic logic [63:0] store_bytes(input logic [63:0] din, input logic [1:0] size);
    logic [63:0] d;
    case (size)
      SZ_BYTE:   d = {56'h0, din[7:0]};
      SZ_HALF:   d = {48'h0, din[15:0]};
      SZ_WORD:   d = {32'h0, din[31:0]};
      SZ_DOUBLE: d = din;
      default:   d = 64'h0;
    endcase
    return d;
  endfunction

  // Sign- or zero-extend right-aligned load data; doubles pass through untouched.
  function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                              input logic uns);
    logic [63:0] r;
    case (size)
      SZ_BYTE:   r = {{56{~uns & raw[7]}},  raw[7:0]};
      SZ_HALF:   r = {{48{~uns & raw[15]}}, raw[15:0]};
      SZ_WORD:   r = {{32{~uns & raw[31]}}, raw[31:0]};
      SZ_DOUBLE: r = raw;
      default:   r = 64'h0;
    endcase
    return r;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] n;
    if (c == {CNT_W{1'b1}}) begin
      n = c;
    end else begin
      n = c + CNT_W'(1);
    end
    return n;
  endfunction

  // Storage: contents are deliberately not reset.
  logic [63:0] mem_q [DEPTH];

  // Response and counter state.
  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rdata_q,     rdata_d;
  logic             err_q,       err_d;
  logic [CNT_W-1:0] ld_cnt_q,    ld_cnt_d;
  logic [CNT_W-1:0] st_cnt_q,    st_cnt_d;

  // Request decode.
  logic [2:0]       lane_s;
  logic [IDX_W-1:0] idx_s;
  logic             oor_s;
  logic             mis_s;
  logic             bad_s;
  logic             good_ld_s;
  logic             good_st_s;
  logic [7:0]       wmask_s;
  logic [63:0]      wdata_s;
  logic [63:0]      rword_s;
  logic [63:0]      rshift_s;
  logic [63:0]      ldata_s;

  assign lane_s    = addr_i[2:0];
  assign idx_s     = addr_i[IDX_W+2:3];
  assign oor_s     = ({1'b0, addr_i} >= LIMIT);
  assign mis_s     = is_misaligned(size_i, lane_s);
  assign bad_s     = oor_s | mis_s;
  assign good_ld_s = req_i & ~we_i & ~bad_s;
  assign good_st_s = req_i &  we_i & ~bad_s;

  // Aligned accesses never cross a word, so shifting by the lane cannot spill.
  assign wmask_s  = size_mask(size_i) << lane_s;
  assign wdata_s  = store_bytes(din_i, size_i) << {lane_s, 3'b000};

  // Read path: pick the word, bring the addressed lane to bit 0, then extend.
  assign rword_s  = mem_q[idx_s];
  assign rshift_s = rword_s >> {lane_s, 3'b000};
  assign ldata_s  = extend_load(rshift_s, size_i, uns_i);

  // Next-state for the response registers and access counters.
  always_comb begin
    rsp_valid_d = req_i;
    err_d       = req_i & bad_s;
    rdata_d     = 64'h0;
    ld_cnt_d    = ld_cnt_q;
    st_cnt_d    = st_cnt_q;
    if (good_ld_s) begin
      rdata_d  = ldata_s;
      ld_cnt_d = sat_inc(ld_cnt_q);
    end else begin
      rdata_d  = 64'h0;
    end
    if (good_st_s) begin
      st_cnt_d = sat_inc(st_cnt_q);
    end else begin
      st_cnt_d = st_cnt_q;
    end
  end

  // Response and counter registers; cleared immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rdata_q     <= 64'h0;
      err_q       <= 1'b0;
      ld_cnt_q    <= {CNT_W{1'b0}};
      st_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      ld_cnt_q    <= ld_cnt_d;
      st_cnt_q    <= st_cnt_d;
    end
  end

  // Byte-lane store commit; a store seen while in reset is dropped, the array keeps its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Nothing to clear: the array holds its contents across reset.
    end else if (good_st_s) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask_s[b]) begin
          mem_q[idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
        end
      end
    end
  end

`ifdef DMEM_INIT_EN
  // Value preloaded into word i for simulation.
  function automatic logic [63:0] init_word(input int i);
    logic [63:0] w;
    case (i)
      1:       w = 64'd10;
      2:       w = 64'd20;
      3:       w = 64'd30;
      4:       w = 64'd40;
      5:       w = 64'hFFFF_FFFF_FFFF_FFF6;
      default: w = 64'd0;
    endcase
    return w;
  endfunction

  // Time-zero preload of the array.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[IDX_W'(i)] = init_word(i);
    end
  end
`else
  // No preload: array contents are undefined until written.
`endif

  assign rsp_valid_o = rsp_valid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign ld_cnt_o    = ld_cnt_q;
  assign st_cnt_o    = st_cnt_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized. Words 0..5 are written explicitly
// with 0,10,20,30,40,-10, so the bench does not depend on DMEM_INIT_EN.
// A second, small instance (DEPTH=16, CNT_W=2) covers the out-of-range
// check and counter saturation.
module tb_data_memory_sized;

  logic        clk;
  logic        rst_n;
  logic        req, we, uns;
  logic [7:0]  addr;
  logic [1:0]  size;
  logic [63:0] din;
  logic        rsp_valid, err;
  logic [63:0] rdata;
  logic [15:0] ld_cnt, st_cnt;

  logic        s_req, s_we, s_uns;
  logic [7:0]  s_addr;
  logic [1:0]  s_size;
  logic [63:0] s_din;
  logic        s_rsp_valid, s_err;
  logic [63:0] s_rdata;
  logic [1:0]  s_ld_cnt, s_st_cnt;

  int n_checks;
  int n_errors;
  logic [15:0] exp_ld;
  logic [15:0] exp_st;

  data_memory_sized #(.DEPTH(32), .ADDR_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .size_i(size),
    .uns_i(uns), .din_i(din), .rsp_valid_o(rsp_valid), .rdata_o(rdata), .err_o(err),
    .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt)
  );

  data_memory_sized #(.DEPTH(16), .ADDR_W(8), .CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .req_i(s_req), .we_i(s_we), .addr_i(s_addr), .size_i(s_size),
    .uns_i(s_uns), .din_i(s_din), .rsp_valid_o(s_rsp_valid), .rdata_o(s_rdata), .err_o(s_err),
    .ld_cnt_o(s_ld_cnt), .st_cnt_o(s_st_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic w, input logic [7:0] a, input logic [1:0] sz,
                       input logic u, input logic [63:0] d);
    req = 1'b1; we = w; addr = a; size = sz; uns = u; din = d;
    @(posedge clk); #1;
  endtask

  task automatic issue_s(input logic w, input logic [7:0] a, input logic [1:0] sz,
                         input logic u, input logic [63:0] d);
    s_req = 1'b1; s_we = w; s_addr = a; s_size = sz; s_uns = u; s_din = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; s_req = 1'b0; s_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rdata !== 64'h0 || err !== 1'b0) begin
      $display("FAIL reset_outputs got v=%b d=%h e=%b want 0", rsp_valid, rdata, err); n_errors++;
    end
    n_checks++;
    if (ld_cnt !== 16'd0 || st_cnt !== 16'd0) begin
      $display("FAIL reset_counters got ld=%0d st=%0d want 0", ld_cnt, st_cnt); n_errors++;
    end
    rst_n = 1'b1;
    idle();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL idle_after_reset got v=%b want 0", rsp_valid); n_errors++;
    end
  endtask

  task automatic test_preload();
    logic [63:0] vals [6];
    vals[0] = 64'd0;  vals[1] = 64'd10; vals[2] = 64'd20;
    vals[3] = 64'd30; vals[4] = 64'd40; vals[5] = 64'hFFFF_FFFF_FFFF_FFF6;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 8'(i * 8), 2'b11, 1'b0, vals[i]);
      exp_st++;
      n_checks++;
      if (rsp_valid !== 1'b1 || err !== 1'b0 || rdata !== 64'h0) begin
        $display("FAIL preload_store%0d got v=%b e=%b d=%h want 1 0 0", i, rsp_valid, err, rdata);
        n_errors++;
      end
    end
    n_checks++;
    if (st_cnt !== exp_st) begin
      $display("FAIL preload_st_cnt got %0d want %0d", st_cnt, exp_st); n_errors++;
    end
  endtask

  task automatic test_loads();
    issue(1'b0, 8'd16, 2'b11, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (rsp_valid !== 1'b1 || err !== 1'b0 || rdata !== 64'd20 || ld_cnt !== 16'd1) begin
      $display("FAIL load_double16 got v=%b e=%b d=%h ld=%0d want 1 0 14 1", rsp_valid, err, rdata, ld_cnt);
      n_errors++;
    end
    issue(1'b0, 8'd40, 2'b00, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_FFF6) begin
      $display("FAIL load_byte_signed got %h want fffffffffffffff6", rdata); n_errors++;
    end
    issue(1'b0, 8'd40, 2'b00, 1'b1, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'h0000_0000_0000_00F6) begin
      $display("FAIL load_byte_unsigned got %h want 00000000000000f6", rdata); n_errors++;
    end
    issue(1'b0, 8'd40, 2'b01, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_FFF6) begin
      $display("FAIL load_half_signed got %h want fffffffffffffff6", rdata); n_errors++;
    end
    issue(1'b0, 8'd44, 2'b10, 1'b1, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'h0000_0000_FFFF_FFFF) begin
      $display("FAIL load_word_unsigned got %h want 00000000ffffffff", rdata); n_errors++;
    end
    issue(1'b0, 8'd44, 2'b10, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_FFFF || ld_cnt !== exp_ld) begin
      $display("FAIL load_word_signed got d=%h ld=%0d want ffffffffffffffff %0d", rdata, ld_cnt, exp_ld);
      n_errors++;
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 8'd8, 2'b11, 1'b0, 64'h0); exp_st++;
    issue(1'b1, 8'd10, 2'b01, 1'b0, 64'h0000_0000_0000_ABCD); exp_st++;
    n_checks++;
    if (rsp_valid !== 1'b1 || err !== 1'b0 || rdata !== 64'h0) begin
      $display("FAIL store_half_rsp got v=%b e=%b d=%h want 1 0 0", rsp_valid, err, rdata); n_errors++;
    end
    issue(1'b0, 8'd8, 2'b11, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'h0000_0000_ABCD_0000) begin
      $display("FAIL store_half_readback got %h want 00000000abcd0000", rdata); n_errors++;
    end
    issue(1'b1, 8'd15, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF5A); exp_st++;
    issue(1'b0, 8'd8, 2'b11, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'h5A00_0000_ABCD_0000) begin
      $display("FAIL store_byte_readback got %h want 5a000000abcd0000", rdata); n_errors++;
    end
    issue(1'b0, 8'd10, 2'b01, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'hFFFF_FFFF_FFFF_ABCD) begin
      $display("FAIL load_half_lane2 got %h want ffffffffffffabcd", rdata); n_errors++;
    end
    issue(1'b0, 8'd12, 2'b10, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'h0000_0000_5A00_0000) begin
      $display("FAIL load_word_lane4 got %h want 000000005a000000", rdata); n_errors++;
    end
    issue(1'b0, 8'd15, 2'b00, 1'b1, 64'h0); exp_ld++;
    n_checks++;
    if (rdata !== 64'h0000_0000_0000_005A || ld_cnt !== exp_ld || st_cnt !== exp_st) begin
      $display("FAIL load_byte_lane7 got d=%h ld=%0d st=%0d want 5a %0d %0d", rdata, ld_cnt, st_cnt, exp_ld, exp_st);
      n_errors++;
    end
  endtask

  task automatic test_errors();
    issue(1'b1, 8'd6, 2'b10, 1'b0, 64'h0000_0000_DEAD_BEEF);
    n_checks++;
    if (err !== 1'b1 || rdata !== 64'h0 || st_cnt !== exp_st) begin
      $display("FAIL misaligned_store got e=%b d=%h st=%0d want 1 0 %0d", err, rdata, st_cnt, exp_st);
      n_errors++;
    end
    issue(1'b0, 8'd1, 2'b01, 1'b0, 64'h0);
    n_checks++;
    if (err !== 1'b1 || rdata !== 64'h0 || ld_cnt !== exp_ld) begin
      $display("FAIL misaligned_load got e=%b d=%h ld=%0d want 1 0 %0d", err, rdata, ld_cnt, exp_ld);
      n_errors++;
    end
    issue(1'b0, 8'd0, 2'b11, 1'b0, 64'h0); exp_ld++;
    n_checks++;
    if (err !== 1'b0 || rdata !== 64'h0 || ld_cnt !== exp_ld) begin
      $display("FAIL word0_unchanged got e=%b d=%h ld=%0d want 0 0 %0d", err, rdata, ld_cnt, exp_ld);
      n_errors++;
    end
    idle();
    n_checks++;
    if (rsp_valid !== 1'b0 || err !== 1'b0 || rdata !== 64'h0) begin
      $display("FAIL idle_clears got v=%b e=%b d=%h want 0 0 0", rsp_valid, err, rdata); n_errors++;
    end
  endtask

  task automatic test_range_and_saturation();
    issue_s(1'b1, 8'd120, 2'b11, 1'b0, 64'h8877_6655_4433_2211);
    issue_s(1'b0, 8'd127, 2'b00, 1'b0, 64'h0);
    n_checks++;
    if (s_err !== 1'b0 || s_rdata !== 64'hFFFF_FFFF_FFFF_FF88 || s_ld_cnt !== 2'd1) begin
      $display("FAIL small_last_byte got e=%b d=%h ld=%0d want 0 ffffffffffffff88 1", s_err, s_rdata, s_ld_cnt);
      n_errors++;
    end
    issue_s(1'b0, 8'd128, 2'b11, 1'b0, 64'h0);
    n_checks++;
    if (s_err !== 1'b1 || s_rdata !== 64'h0 || s_rsp_valid !== 1'b1 || s_ld_cnt !== 2'd1) begin
      $display("FAIL out_of_range_load got e=%b d=%h v=%b ld=%0d want 1 0 1 1", s_err, s_rdata, s_rsp_valid, s_ld_cnt);
      n_errors++;
    end
    issue_s(1'b1, 8'd200, 2'b00, 1'b0, 64'h0);
    n_checks++;
    if (s_err !== 1'b1 || s_st_cnt !== 2'd1) begin
      $display("FAIL out_of_range_store got e=%b st=%0d want 1 1", s_err, s_st_cnt); n_errors++;
    end
    issue_s(1'b0, 8'd124, 2'b10, 1'b1, 64'h0);
    n_checks++;
    if (s_rdata !== 64'h0000_0000_8877_6655 || s_ld_cnt !== 2'd2) begin
      $display("FAIL small_word_load got d=%h ld=%0d want 0000000088776655 2", s_rdata, s_ld_cnt);
      n_errors++;
    end
    for (int i = 0; i < 3; i++) begin
      issue_s(1'b0, 8'd120, 2'b11, 1'b0, 64'h0);
      n_checks++;
      if (s_ld_cnt !== 2'd3) begin
        $display("FAIL ld_cnt_saturate step%0d got %0d want 3", i, s_ld_cnt); n_errors++;
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 8'd24, 2'b11, 1'b0, 64'h0);
    n_checks++;
    if (rdata !== 64'd30) begin
      $display("FAIL pre_reset_load got %h want 1e", rdata); n_errors++;
    end
    rst_n = 1'b0;
    we = 1'b1; addr = 8'd24; size = 2'b11; din = 64'h1111; req = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rdata !== 64'h0 || err !== 1'b0 || ld_cnt !== 16'd0 || st_cnt !== 16'd0) begin
      $display("FAIL async_reset got v=%b d=%h e=%b ld=%0d st=%0d want all 0", rsp_valid, rdata, err, ld_cnt, st_cnt);
      n_errors++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    n_checks++;
    if (rsp_valid !== 1'b0 || st_cnt !== 16'd0) begin
      $display("FAIL post_release_idle got v=%b st=%0d want 0 0", rsp_valid, st_cnt); n_errors++;
    end
    issue(1'b0, 8'd24, 2'b11, 1'b0, 64'h0);
    n_checks++;
    if (rdata !== 64'd30 || ld_cnt !== 16'd1) begin
      $display("FAIL store_in_reset_dropped got d=%h ld=%0d want 1e 1", rdata, ld_cnt); n_errors++;
    end
    idle();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_ld = 16'd0; exp_st = 16'd0;
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; uns = 1'b0; addr = 8'd0; size = 2'b00; din = 64'h0;
    s_req = 1'b0; s_we = 1'b0; s_uns = 1'b0; s_addr = 8'd0; s_size = 2'b00; s_din = 64'h0;
    test_reset();
    test_preload();
    test_loads();
    test_back_to_back();
    test_errors();
    test_range_and_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
